// File: rtl/enigma_pkg.sv
// Shared ENIGMA551 definitions: alphabet size, letter type and rotor II wiring tables.
// Both the forward and the reverse rotor II stages take their tables from here.
package enigma_pkg;

    localparam int unsigned ALPHA    = 26;
    localparam int unsigned LETTER_W = 5;

    typedef logic [LETTER_W-1:0] letter_t;

    localparam letter_t ROTOR2_FWD [ALPHA] = '{
        5'd7,  5'd0,  5'd14, 5'd2,  5'd9,  5'd21, 5'd5,  5'd23, 5'd1,
        5'd19, 5'd11, 5'd4,  5'd24, 5'd22, 5'd25, 5'd13, 5'd8,  5'd6,
        5'd18, 5'd3,  5'd16, 5'd15, 5'd20, 5'd12, 5'd10, 5'd17
    };

    localparam letter_t ROTOR2_INV [ALPHA] = '{
        5'd1,  5'd8,  5'd3,  5'd19, 5'd11, 5'd6,  5'd17, 5'd0,  5'd16,
        5'd4,  5'd24, 5'd10, 5'd23, 5'd15, 5'd2,  5'd21, 5'd20, 5'd25,
        5'd18, 5'd9,  5'd22, 5'd5,  5'd13, 5'd7,  5'd12, 5'd14
    };

    function automatic logic letter_in_range(input letter_t x);
        return x < letter_t'(ALPHA);
    endfunction

    // Values 26..31 wrap once into the alphabet
    function automatic letter_t letter_fold(input letter_t x);
        letter_t r;
        r = x;
        if (!letter_in_range(x)) begin
            r = x - letter_t'(ALPHA);
        end
        return r;
    endfunction

    // (a - b) mod 26 for a, b in 0..25 using 5-bit wraparound plus one conditional add
    function automatic letter_t letter_sub(input letter_t a, input letter_t b);
        letter_t d;
        d = a - b;
        if (a < b) begin
            d = d + letter_t'(ALPHA);
        end
        return d;
    endfunction

    function automatic letter_t rotor2_fwd(input letter_t x);
        letter_t r;
        r = '0;
        if (letter_in_range(x)) begin
            r = ROTOR2_FWD[x];
        end
        return r;
    endfunction

endpackage

// File: rtl/rotor2_inv_lut.sv
// Combinational rotor II inverse wiring lookup; out-of-range letters map to 0.
module rotor2_inv_lut
    import enigma_pkg::*;
(
    input  letter_t i_letter,
    output letter_t o_letter
);

    always_comb begin
        o_letter = '0;
        if (letter_in_range(i_letter)) begin
            o_letter = ROTOR2_INV[i_letter];
        end
    end

endmodule

// File: rtl/rotor2_reverse.sv
// Rotor II return-path stage: inverse substitution through a 2-stage valid/ready pipeline
// with its own position register. Optional input range check via ROTOR2_REV_INPUT_CHECK_EN.
module rotor2_reverse
    import enigma_pkg::*;
#(
    parameter letter_t NOTCH = 5'd4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    pos_load,
    input  letter_t pos_value,
    input  logic    step,
    input  logic    in_valid,
    input  letter_t in_data,
    output logic    in_ready,
    output logic    out_valid,
    output letter_t out_data,
    input  logic    out_ready,
    output letter_t position,
    output logic    notch_out
`ifdef ROTOR2_REV_INPUT_CHECK_EN
    ,
    output logic    err
`endif
);

    logic    w_s2_load;
    logic    w_s1_load;
    logic    w_keep;
    letter_t w_lut_in;
    letter_t w_lut_out;
    letter_t w_diff;

    logic    r_s1_valid;
    letter_t r_s1_inv;
    letter_t r_s1_pos;
    logic    r_s2_valid;
    letter_t r_s2_data;
    letter_t r_position;
    logic    r_notch;

    // Each stage advances when it is empty or the stage after it is moving
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;

`ifdef ROTOR2_REV_INPUT_CHECK_EN
    logic w_accept;
    logic w_in_bad;
    logic r_err;

    assign w_accept = in_valid && w_s1_load;
    assign w_in_bad = !letter_in_range(in_data);
    assign w_keep   = in_valid && !w_in_bad;
    assign w_lut_in = in_data;

    // Bad letters complete the handshake but never enter the pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept && w_in_bad) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_keep   = in_valid;
    assign w_lut_in = letter_fold(in_data);
`endif

    rotor2_inv_lut u_inv_lut (
        .i_letter (w_lut_in),
        .o_letter (w_lut_out)
    );

    // Stage 1: inverse-wired letter and the position it was accepted under
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_inv   <= '0;
            r_s1_pos   <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= w_keep;
            if (w_keep) begin
                r_s1_inv <= w_lut_out;
                r_s1_pos <= r_position;
            end
        end
    end

    assign w_diff = letter_sub(r_s1_inv, r_s1_pos);

    // Stage 2: offset-corrected letter, drives the output port directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_diff;
            end
        end
    end

    // Position register: load beats step, notch pulses when a step leaves NOTCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_position <= '0;
            r_notch    <= 1'b0;
        end else begin
            r_notch <= step && !pos_load && (r_position == NOTCH);
            if (pos_load) begin
                r_position <= letter_in_range(pos_value) ? pos_value : letter_t'(0);
            end else if (step) begin
                if (r_position == letter_t'(ALPHA - 1)) begin
                    r_position <= '0;
                end else begin
                    r_position <= r_position + letter_t'(1);
                end
            end
        end
    end

    assign in_ready  = w_s1_load;
    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign position  = r_position;
    assign notch_out = r_notch;

endmodule

// File: tb/tb_rotor2_reverse.sv
// Directed self-checking bench for rotor2_reverse with hand-computed expectations.
`timescale 1ns/1ps
module tb_rotor2_reverse;

    logic       clk;
    logic       rst_n;
    logic       pos_load;
    logic [4:0] pos_value;
    logic       step;
    logic       in_valid;
    logic [4:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [4:0] out_data;
    logic       out_ready;
    logic [4:0] position;
    logic       notch_out;
`ifdef ROTOR2_REV_INPUT_CHECK_EN
    logic       err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Rotor II forward wiring, used to build round-trip stimulus
    int fwd [26] = '{7, 0, 14, 2, 9, 21, 5, 23, 1, 19, 11, 4, 24,
                     22, 25, 13, 8, 6, 18, 3, 16, 15, 20, 12, 10, 17};

    rotor2_reverse dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pos_load  (pos_load),
        .pos_value (pos_value),
        .step      (step),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .position  (position),
        .notch_out (notch_out)
`ifdef ROTOR2_REV_INPUT_CHECK_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_pos(input int v);
        pos_load  = 1'b1;
        pos_value = 5'(v);
        tick();
        pos_load  = 1'b0;
    endtask

    // One letter through an idle pipeline with out_ready high
    task automatic xact(input string tag, input int d, input int exp);
        logic seen;
        in_valid  = 1'b1;
        in_data   = 5'(d);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else tick();
        end
        check({tag, "_valid"}, int'(seen), 1);
        check(tag, int'(out_data), exp);
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        pos_load  = 1'b0;
        pos_value = '0;
        step      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) tick();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data",  int'(out_data), 0);
        check("rst_position",  int'(position), 0);
        check("rst_notch",     int'(notch_out), 0);
`ifdef ROTOR2_REV_INPUT_CHECK_EN
        check("rst_err",       int'(err), 0);
`endif
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", int'(in_ready), 1);

        // Latency: accept at edge N, valid after N+2
        in_valid = 1'b1;
        in_data  = 5'd7;
        tick();
        in_valid = 1'b0;
        check("lat_n1_valid", int'(out_valid), 0);
        tick();
        check("lat_n2_valid", int'(out_valid), 1);
        check("lat_n2_data",  int'(out_data), 0);
        tick();
        check("lat_drained", int'(out_valid), 0);

        load_pos(3);
        xact("p3_in2", 2, 0);
        load_pos(25);
        xact("p25_in2", 2, 4);

        // Round trip against the forward wiring
        for (int p = 0; p < 26; p++) begin
            load_pos(p);
            for (int x = 0; x < 26; x++) begin
                xact($sformatf("rt_p%0d_x%0d", p, x), fwd[(x + p) % 26], x);
            end
        end

        // Backpressure: two letters fill the pipe, third waits
        load_pos(0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 5'd7;
        #1;
        check("bp_ready0", int'(in_ready), 1);
        tick();
        in_data = 5'd0;
        #1;
        check("bp_ready1", int'(in_ready), 1);
        tick();
        in_data = 5'd1;
        #1;
        check("bp_ready_drop", int'(in_ready), 0);
        tick();
        check("bp_hold_ready", int'(in_ready), 0);
        check("bp_hold_valid", int'(out_valid), 1);
        check("bp_hold_data",  int'(out_data), 0);
        tick();
        check("bp_hold2_data", int'(out_data), 0);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("bp_out2", int'(out_data), 1);
        check("bp_out2_valid", int'(out_valid), 1);
        tick();
        check("bp_out3", int'(out_data), 8);
        check("bp_out3_valid", int'(out_valid), 1);
        tick();
        check("bp_empty", int'(out_valid), 0);

        // Position register behaviour
        load_pos(24);
        check("pos_load24", int'(position), 24);
        step = 1'b1;
        tick();
        check("pos_step25", int'(position), 25);
        tick();
        check("pos_wrap0", int'(position), 0);
        tick();
        check("pos_step1", int'(position), 1);
        check("pos_no_notch", int'(notch_out), 0);
        step = 1'b0;
        load_pos(4);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("notch_pos5", int'(position), 5);
        check("notch_high", int'(notch_out), 1);
        tick();
        check("notch_low", int'(notch_out), 0);
        load_pos(4);
        pos_load  = 1'b1;
        pos_value = 5'd10;
        step      = 1'b1;
        tick();
        pos_load = 1'b0;
        step     = 1'b0;
        check("load_beats_step", int'(position), 10);
        check("load_no_notch", int'(notch_out), 0);
        load_pos(30);
        check("load_oor_zero", int'(position), 0);
        load_pos(3);
        in_valid = 1'b1;
        in_data  = 5'd2;
        step     = 1'b1;
        tick();
        in_valid = 1'b0;
        step     = 1'b0;
        check("step_acc_pos", int'(position), 4);
        tick();
        check("step_acc_valid", int'(out_valid), 1);
        check("step_acc_data",  int'(out_data), 0);
        tick();

        load_pos(0);
`ifdef ROTOR2_REV_INPUT_CHECK_EN
        in_valid = 1'b1;
        in_data  = 5'd27;
        #1;
        check("bad_in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("bad_err_set", int'(err), 1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bad_no_out%0d", i), int'(out_valid), 0);
            tick();
        end
        check("bad_err_held", int'(err), 1);
        xact("after_bad_in0", 0, 1);
`else
        xact("fold27", 27, 8);
        xact("fold26", 26, 1);
`endif

        // Reset with a full pipeline
        load_pos(5);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 5'd7;
        tick();
        tick();
        in_valid = 1'b0;
        check("full_valid", int'(out_valid), 1);
        check("full_ready", int'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_data",  int'(out_data), 0);
        check("midrst_pos",   int'(position), 0);
`ifdef ROTOR2_REV_INPUT_CHECK_EN
        check("midrst_err",   int'(err), 0);
`endif
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("postrst_no_stale%0d", i), int'(out_valid), 0);
        end
        check("postrst_ready", int'(in_ready), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
